// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH      = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // One prefetch buffer entry: instruction word tagged with its PC.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, inst} entries with push/pop/clear and occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller never pushes when full and never pops when empty.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_ent_t    push_dat,
  input  logic          pop,
  input  logic          clear,
  output fetch_ent_t    head_dat,
  output logic [CW-1:0] count
);

  fetch_ent_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and count update; clear wins over any same-cycle push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage; no reset needed because the head is qualified by count.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/riscv_inst_fetch.sv
// Instruction fetch: PC, 1-cycle SRAM word reads, prefetch FIFO, redirect-with-kill, sticky halt+drain.
// Latency: reset->INST_VALID 2 cycles, redirect->INST_VALID 3 cycles, 1 inst/cycle steady state.
// Backpressure: stops issuing once FIFO+in-flight reach DEPTH; head held stable while !INST_READY. FETCH_PERF_EN adds counters.
module riscv_inst_fetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter int          AWIDTH   = 12
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              I_MEM_CSN,
  output logic [AWIDTH-1:0] I_MEM_ADDR,
  input  logic [31:0]       I_MEM_DI,
  input  logic              REDIRECT_VALID,
  input  logic [31:0]       REDIRECT_PC,
  input  logic              HALT,
  output logic              INST_VALID,
  input  logic              INST_READY,
  output logic [31:0]       INST,
  output logic [31:0]       INST_PC,
`ifdef FETCH_PERF_EN
  output logic [31:0]       FETCH_CNT,
  output logic [31:0]       STALL_CNT,
`endif
  output logic              FETCH_IDLE
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ifl_pc_q, ifl_pc_d;
  logic          ifl_q, ifl_d;

  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occ;
  fetch_ent_t    head;
  fetch_ent_t    push_ent;
  logic          redir_take;
  logic          issue;
  logic          pop;
  logic          push;

  // Redirects are honoured everywhere except in the terminal HALTED state.
  assign redir_take = REDIRECT_VALID && (state_q != HALTED);
  assign occ        = {1'b0, fifo_cnt} + (CW+1)'(ifl_q);
  assign pop        = INST_VALID && INST_READY;

  // A word may be requested when a FIFO slot is guaranteed for it next cycle.
  assign issue = !RST && ((state_q == RUN) || (state_q == FLUSH)) && !HALT && !REDIRECT_VALID &&
                 ((occ < (CW+1)'(DEPTH)) || pop);

  // The word returning during a redirect cycle is the killed in-flight read.
  assign push     = ifl_q && !redir_take;
  assign push_ent = '{pc: ifl_pc_q, inst: I_MEM_DI};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .clear    (redir_take),
    .head_dat (head),
    .count    (fifo_cnt)
  );

  // Next PC, in-flight tracking and fetch state transitions.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ifl_d    = issue;
    ifl_pc_d = pc_q;
    if (issue)      pc_d = pc_q + PC_STEP;
    if (redir_take) pc_d = REDIRECT_PC & ~32'h3;
    unique case (state_q)
      RUN, FLUSH: begin
        if (HALT)            state_d = HALT_DRAIN;
        else if (redir_take) state_d = FLUSH;
        else                 state_d = RUN;
      end
      HALT_DRAIN: begin
        if ((fifo_cnt == '0) && !ifl_q) state_d = HALTED;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Fetch state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      ifl_q    <= 1'b0;
      ifl_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ifl_q    <= ifl_d;
      ifl_pc_q <= ifl_pc_d;
    end
  end

  assign I_MEM_CSN  = !issue;
  assign I_MEM_ADDR = pc_q[AWIDTH-1:0];
  assign INST_VALID = (fifo_cnt != '0);
  assign INST       = INST_VALID ? head.inst : '0;
  assign INST_PC    = INST_VALID ? head.pc   : '0;
  assign FETCH_IDLE = (state_q == HALTED);

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters: accepted pushes and consumer stall cycles.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (push && (fetch_cnt_q != '1))                      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (INST_VALID && !INST_READY && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_inst_fetch.sv
// Self-checking bench for riscv_inst_fetch: directed scenarios plus randomized ready/redirect traffic.
// Reference: delivered stream must be consecutive words from the current fetch target, read from the memory image.
// Inputs driven on the falling edge, outputs sampled 1 ns after it.
module tb_riscv_inst_fetch;

  localparam int          DEPTH    = 2;
  localparam int          AWIDTH   = 12;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              I_MEM_CSN;
  logic [AWIDTH-1:0] I_MEM_ADDR;
  logic [31:0]       I_MEM_DI = '0;
  logic              REDIRECT_VALID = 1'b0;
  logic [31:0]       REDIRECT_PC = '0;
  logic              HALT = 1'b0;
  logic              INST_VALID;
  logic              INST_READY = 1'b0;
  logic [31:0]       INST;
  logic [31:0]       INST_PC;
  logic              FETCH_IDLE;
`ifdef FETCH_PERF_EN
  logic [31:0]       FETCH_CNT;
  logic [31:0]       STALL_CNT;
`endif

  riscv_inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .I_MEM_CSN      (I_MEM_CSN),
    .I_MEM_ADDR     (I_MEM_ADDR),
    .I_MEM_DI       (I_MEM_DI),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_PC    (REDIRECT_PC),
    .HALT           (HALT),
    .INST_VALID     (INST_VALID),
    .INST_READY     (INST_READY),
    .INST           (INST),
    .INST_PC        (INST_PC),
`ifdef FETCH_PERF_EN
    .FETCH_CNT      (FETCH_CNT),
    .STALL_CNT      (STALL_CNT),
`endif
    .FETCH_IDLE     (FETCH_IDLE)
  );

  always #5 CLK = ~CLK;

  // Single-port SRAM image with one-cycle read latency.
  logic [31:0] mem [1024];
  always @(posedge CLK) begin
    if (!I_MEM_CSN) I_MEM_DI <= mem[I_MEM_ADDR[11:2]];
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  int          n_issue = 0;
  int          n_stall = 0;
  int          h_acc;
  logic [31:0] exp_pc = RESET_PC;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: scoreboard the settled outputs, then advance to the next falling edge.
  task automatic tick();
    #1;
    if (REDIRECT_VALID) chk("csn_on_redirect", 32'(I_MEM_CSN), 32'd1);
    if (!I_MEM_CSN) n_issue++;
    if (INST_VALID && !INST_READY) n_stall++;
    if (INST_VALID && INST_READY) begin
      chk("inst_pc", INST_PC, exp_pc);
      chk("inst", INST, mem[exp_pc[11:2]]);
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    if (REDIRECT_VALID && !FETCH_IDLE) exp_pc = REDIRECT_PC & ~32'h3;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REDIRECT_VALID = 1'b0;
    HALT = 1'b0;
    INST_READY = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_csn",   32'(I_MEM_CSN),  32'd1);
    chk("rst_addr",  32'(I_MEM_ADDR), 32'h000);
    chk("rst_valid", 32'(INST_VALID), 32'd0);
    chk("rst_inst",  INST,            32'd0);
    chk("rst_pc",    INST_PC,         32'd0);
    chk("rst_idle",  32'(FETCH_IDLE), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    exp_pc = RESET_PC;
    n_acc = 0;
    n_stall = 0;
    n_issue = 0;
  endtask

  // Pulse a redirect (with the consumer ready) and return at the following cycle.
  task automatic redirect(input logic [31:0] tgt);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC = tgt;
    tick();
    REDIRECT_VALID = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    @(negedge CLK);

    // Reset release and first-fetch latency, then streaming.
    do_reset();
    INST_READY = 1'b1;
    #1;
    chk("c0_csn",   32'(I_MEM_CSN),  32'd0);
    chk("c0_addr",  32'(I_MEM_ADDR), 32'h000);
    chk("c0_valid", 32'(INST_VALID), 32'd0);
    tick();
    #1 chk("c1_valid", 32'(INST_VALID), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      #1 chk("stream_valid", 32'(INST_VALID), 32'd1);
      tick();
    end
    chk("stream_count", 32'(n_acc), 32'd6);

    // Consumer stall: bounded issues, head held, nothing lost on release.
    INST_READY = 1'b0;
    n_issue = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i >= 1) chk("stall_csn", 32'(I_MEM_CSN), 32'd1);
      chk("stall_head_pc", INST_PC, exp_pc);
      chk("stall_head",    INST,    mem[exp_pc[11:2]]);
      tick();
    end
    chk("stall_issues", 32'(n_issue <= DEPTH), 32'd1);
    INST_READY = 1'b1;
    repeat (6) tick();

    // Redirect while streaming: three cycles to the new target.
    redirect(32'h40);
    #1 chk("redir_v1", 32'(INST_VALID), 32'd0);
    tick();
    #1 chk("redir_v2", 32'(INST_VALID), 32'd0);
    tick();
    #1;
    chk("redir_v3",  32'(INST_VALID), 32'd1);
    chk("redir_pc3", INST_PC,         32'h40);
    repeat (3) tick();

    // Unaligned target is word-aligned.
    redirect(32'h43);
    #1 chk("unal_addr", 32'(I_MEM_ADDR), 32'h040);
    repeat (5) tick();

    // Address wrap at 2^AWIDTH while INST_PC keeps counting.
    redirect(32'hFFC);
    #1;
    chk("wrap_csn0",  32'(I_MEM_CSN),  32'd0);
    chk("wrap_addr0", 32'(I_MEM_ADDR), 32'hFFC);
    tick();
    #1;
    chk("wrap_csn1",  32'(I_MEM_CSN),  32'd0);
    chk("wrap_addr1", 32'(I_MEM_ADDR), 32'h000);
    tick();
    #1 chk("wrap_pc_ffc", INST_PC, 32'hFFC);
    tick();
    #1 chk("wrap_pc_1000", INST_PC, 32'h1000);
    repeat (3) tick();

    // Halt with one buffered and one in flight: both delivered, then idle.
    do_reset();
    INST_READY = 1'b1;
    repeat (5) tick();
    HALT = 1'b1;
    INST_READY = 1'b0;
    h_acc = n_acc;
    n_issue = 0;
    tick();
    HALT = 1'b0;
    INST_READY = 1'b1;
    for (int i = 0; i < 20 && !FETCH_IDLE; i++) tick();
    #1;
    chk("halt_delivered", 32'(n_acc - h_acc), 32'd2);
    chk("halt_issues",    32'(n_issue),       32'd0);
    chk("halt_idle",      32'(FETCH_IDLE),    32'd1);
    chk("halt_valid",     32'(INST_VALID),    32'd0);
    redirect(32'h80);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halted_csn",   32'(I_MEM_CSN),  32'd1);
      chk("halted_idle",  32'(FETCH_IDLE), 32'd1);
      chk("halted_valid", 32'(INST_VALID), 32'd0);
      tick();
    end

    // Reset clears the halt; streaming resumes from RESET_PC.
    do_reset();
    INST_READY = 1'b1;
    tick();
    tick();
    #1 chk("rehalt_valid", 32'(INST_VALID), 32'd1);
    repeat (3) tick();

    // Randomized consumer readiness and redirects.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      INST_READY = ($urandom_range(0, 3) != 0);
      REDIRECT_VALID = ($urandom_range(0, 15) == 0);
      REDIRECT_PC = $urandom;
      tick();
    end
    REDIRECT_VALID = 1'b0;
    chk("rand_progress", 32'(n_acc > 150), 32'd1);
    HALT = 1'b1;
    tick();
    HALT = 1'b0;
    for (int i = 0; i < 40 && !FETCH_IDLE; i++) begin
      INST_READY = ($urandom_range(0, 1) != 0);
      tick();
    end
    #1 chk("rand_idle", 32'(FETCH_IDLE), 32'd1);

`ifdef FETCH_PERF_EN
    // Performance counters: accepted words and stall cycles.
    do_reset();
    INST_READY = 1'b1;
    repeat (12) tick();
    INST_READY = 1'b0;
    repeat (3) tick();
    INST_READY = 1'b1;
    HALT = 1'b1;
    tick();
    HALT = 1'b0;
    for (int i = 0; i < 20 && !FETCH_IDLE; i++) tick();
    #1;
    chk("perf_fetch", FETCH_CNT, 32'(n_acc));
    chk("perf_stall", STALL_CNT, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
